// File: rtl/case_7_mac_pkg.sv
// case_7_mac_pkg: shared widths, FSM states and the accumulate-add helper (CASE_7_MAC_SAT_EN selects saturate vs wrap)
package case_7_mac_pkg;
  localparam int C_DIN0_W = 9;
  localparam int C_DIN1_W = 6;
  localparam int C_PROD_W = 9;
  localparam int C_ACC_W = 16;
  localparam int C_MAX_LEN = 256;
  localparam int C_CNT_W = $clog2(C_MAX_LEN) + 1;
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic clamped;
    logic [C_ACC_W-1:0] sum;
  } add_t;
  // Sign-extends the product onto the accumulator; clamps to the signed range when saturation is built in, wraps otherwise
  function automatic add_t acc_add(input logic signed [C_ACC_W-1:0] acc, input logic signed [C_PROD_W-1:0] prod);
    add_t r;
`ifdef CASE_7_MAC_SAT_EN
    logic signed [C_ACC_W:0] s;
    s = (C_ACC_W+1)'(acc) + (C_ACC_W+1)'(prod);
    r.clamped = s[C_ACC_W] ^ s[C_ACC_W-1];
    r.sum = r.clamped ? {s[C_ACC_W], {(C_ACC_W-1){~s[C_ACC_W]}}} : s[C_ACC_W-1:0];
`else
    r.clamped = 1'b0;
    r.sum = acc + C_ACC_W'(prod);
`endif
    return r;
  endfunction
endpackage

// File: rtl/case_7_mul_9s_6s_9_1_1.sv
// case_7_mul_9s_6s_9_1_1: combinational signed multiplier, product truncated to dout_WIDTH low bits
module case_7_mul_9s_6s_9_1_1 #(
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 9
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);
  localparam int W = din0_WIDTH + din1_WIDTH;
  logic signed [W-1:0] w_a;
  logic signed [W-1:0] w_b;
  logic signed [W-1:0] w_p;
  assign w_a = W'($signed(din0));
  assign w_b = W'($signed(din1));
  assign w_p = w_a * w_b;
  assign dout = dout_WIDTH'(w_p);
endmodule

// File: rtl/case_7_mac_acc.sv
// case_7_mac_acc: framed signed multiply-accumulate with valid/ready result; CASE_7_MAC_SAT_EN enables saturating add
module case_7_mac_acc
  import case_7_mac_pkg::*;
#(
  parameter int DIN0_W = C_DIN0_W,
  parameter int DIN1_W = C_DIN1_W,
  parameter int PROD_W = C_PROD_W,
  parameter int ACC_W = C_ACC_W,
  parameter int MAX_LEN = C_MAX_LEN,
  localparam int CNT_W = $clog2(MAX_LEN) + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  input  logic              in_vld,
  input  logic              in_last,
  output logic              in_rdy,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              sat,
  output logic              len_err,
  output logic              out_vld,
  input  logic              out_rdy
);
  state_t r_state;
  logic r_s1_vld, r_s1_close, r_s2_vld, r_s2_close;
  logic [DIN0_W-1:0] r_s1_a;
  logic [DIN1_W-1:0] r_s1_b;
  logic signed [PROD_W-1:0] r_s2_p;
  logic [PROD_W-1:0] w_prod;
  logic [CNT_W-1:0] r_in_cnt, r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic r_sat, r_len_err, r_out_vld;
  logic w_acc, w_full, w_close;
  add_t w_add;
  assign in_rdy = (r_state == ACC) & ~r_out_vld;
  assign w_acc = in_vld & in_rdy;
  assign w_full = r_in_cnt == CNT_W'(MAX_LEN - 1);
  assign w_close = w_acc & (in_last | w_full);
  assign w_add = acc_add(r_acc, r_s2_p);
  assign acc_out = r_acc;
  assign beat_cnt = r_cnt;
  assign len_err = r_len_err;
  assign out_vld = r_out_vld;
`ifdef CASE_7_MAC_SAT_EN
  assign sat = r_sat;
`else
  assign sat = 1'b0;
`endif
  case_7_mul_9s_6s_9_1_1 #(
    .din0_WIDTH(DIN0_W),
    .din1_WIDTH(DIN1_W),
    .dout_WIDTH(PROD_W)
  ) u_mul (
    .din0(r_s1_a),
    .din1(r_s1_b),
    .dout(w_prod)
  );
  // Operand (S1) and product (S2) stages; the close flag travels with the beat that ends the frame
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_close <= 1'b0;
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s2_vld <= 1'b0;
      r_s2_close <= 1'b0;
      r_s2_p <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
      if (w_acc) begin
        r_s1_a <= din0;
        r_s1_b <= din1;
        r_s1_close <= w_close;
      end
      if (r_s1_vld) begin
        r_s2_p <= w_prod;
        r_s2_close <= r_s1_close;
      end
    end
  end
  // Frame FSM, accumulator and sticky flags; accept count runs ahead of beat_cnt to close the frame at MAX_LEN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ACC;
      r_in_cnt <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_sat <= 1'b0;
      r_len_err <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (r_state == HOLD) begin
      if (out_rdy) begin
        r_state <= ACC;
        r_cnt <= '0;
        r_acc <= '0;
        r_sat <= 1'b0;
        r_len_err <= 1'b0;
        r_out_vld <= 1'b0;
      end
    end else begin
      if (w_acc) r_in_cnt <= w_close ? '0 : r_in_cnt + CNT_W'(1);
      if (w_close) r_state <= DRAIN;
      if (w_close & w_full & ~in_last) r_len_err <= 1'b1;
      if (r_s2_vld) begin
        r_acc <= w_add.sum;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_add.clamped) r_sat <= 1'b1;
        if (r_s2_close) begin
          r_out_vld <= 1'b1;
          r_state <= HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_case_7_mac_acc.sv
// tb_case_7_mac_acc: directed frames with a result scoreboard popped by an independent monitor
module tb_case_7_mac_acc;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [8:0] din0 = '0;
  logic [5:0] din1 = '0;
  logic in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b1;
  logic in_rdy, sat, len_err, out_vld;
  logic [15:0] acc_out;
  logic [8:0] beat_cnt;
  typedef struct {
    logic [15:0] acc;
    logic [8:0] cnt;
    logic sat;
    logic len;
  } exp_t;
  exp_t q[$];
  int n_pass = 0, n_tot = 0;
  case_7_mac_acc dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1), .in_vld(in_vld),
    .in_last(in_last), .in_rdy(in_rdy), .acc_out(acc_out), .beat_cnt(beat_cnt),
    .sat(sat), .len_err(len_err), .out_vld(out_vld), .out_rdy(out_rdy)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask
  task automatic push(input logic [15:0] a, input logic [8:0] c, input logic s, input logic l);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.sat = s;
    e.len = l;
    q.push_back(e);
  endtask
  task automatic beat(input logic [8:0] a, input logic [5:0] b, input logic last);
    int n = 0;
    din0 = a;
    din1 = b;
    in_last = last;
    in_vld = 1'b1;
    while (!in_rdy && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) chk("beat_timeout", 32'(in_rdy), 1);
    else begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
  endtask
  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 32'(q.size()), 0);
    @(negedge ap_clk);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ap_clk);
      #1;
      if (out_vld && out_rdy && !ap_rst) begin
        if (q.size() == 0) chk("unexpected_result", 32'(out_vld), 0);
        else begin
          e = q.pop_front();
          chk("res_acc", 32'(acc_out), 32'(e.acc));
          chk("res_cnt", 32'(beat_cnt), 32'(e.cnt));
          chk("res_sat", 32'(sat), 32'(e.sat));
          chk("res_len_err", 32'(len_err), 32'(e.len));
        end
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin : stim
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    push(16'hFFD4, 9'd4, 1'b0, 1'b0);
    beat(9'd10, 6'd3, 1'b0);
    beat(-9'sd7, 6'd5, 1'b0);
    beat(9'd20, -6'sd2, 1'b0);
    beat(9'd1, 6'd1, 1'b1);
    in_vld = 1'b0;
    chk("lat_k0_out_vld", 32'(out_vld), 0);
    @(negedge ap_clk);
    chk("lat_k1_out_vld", 32'(out_vld), 0);
    @(negedge ap_clk);
    chk("lat_k2_out_vld", 32'(out_vld), 1);
    chk("lat_k2_in_rdy", 32'(in_rdy), 0);
    @(negedge ap_clk);
    chk("post_hs_in_rdy", 32'(in_rdy), 1);
    chk("post_hs_out_vld", 32'(out_vld), 0);
    chk("post_hs_acc", 32'(acc_out), 0);
    push(16'hFFF4, 9'd1, 1'b0, 1'b0);
    beat(9'd100, 6'd5, 1'b1);
    in_vld = 1'b0;
    wait_empty();
    push(16'h0000, 9'd1, 1'b0, 1'b0);
    beat(-9'sd256, -6'sd32, 1'b1);
    in_vld = 1'b0;
    wait_empty();
`ifdef CASE_7_MAC_SAT_EN
    push(16'h7FFF, 9'd129, 1'b1, 1'b0);
`else
    push(16'h807F, 9'd129, 1'b0, 1'b0);
`endif
    for (int i = 1; i <= 129; i++) beat(9'd255, 6'd1, i == 129);
    in_vld = 1'b0;
    wait_empty();
    push(16'h0100, 9'd256, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) beat(9'd1, 6'd1, 1'b0);
    chk("len_in_rdy_drop", 32'(in_rdy), 0);
    in_vld = 1'b0;
    wait_empty();
    out_rdy = 1'b0;
    push(16'd12, 9'd1, 1'b0, 1'b0);
    beat(9'd3, 6'd4, 1'b1);
    in_vld = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    din0 = 9'd7;
    din1 = 6'd1;
    in_last = 1'b1;
    in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy", 32'(in_rdy), 0);
      chk("bp_out_vld", 32'(out_vld), 1);
      chk("bp_acc", 32'(acc_out), 12);
      @(negedge ap_clk);
    end
    out_rdy = 1'b1;
    push(16'd7, 9'd1, 1'b0, 1'b0);
    beat(9'd7, 6'd1, 1'b1);
    in_vld = 1'b0;
    wait_empty();
    beat(9'd5, 6'd5, 1'b0);
    beat(9'd6, 6'd6, 1'b0);
    in_vld = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("pre_rst_acc", 32'(acc_out), 61);
    #3 ap_rst = 1'b1;
    #1;
    chk("mid_rst_acc", 32'(acc_out), 0);
    chk("mid_rst_cnt", 32'(beat_cnt), 0);
    chk("mid_rst_out_vld", 32'(out_vld), 0);
    chk("mid_rst_sat", 32'(sat), 0);
    chk("mid_rst_len_err", 32'(len_err), 0);
    #2 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("after_rst_in_rdy", 32'(in_rdy), 1);
    push(16'd4, 9'd1, 1'b0, 1'b0);
    beat(9'd2, 6'd2, 1'b1);
    in_vld = 1'b0;
    wait_empty();
    repeat (3) @(negedge ap_clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
